multi_edge_detector: RTL and testbench
======================================

MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter FILT_LEN, default 1: consecutive stable samples needed to accept a level change, range 1..255.
REQ-003 Parameter CNT_W, default 8: width of each per-channel event counter, range 1..16.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 level  input  N_CH  raw input levels, bit i = channel i.
REQ-007 mode  input  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 clr  input  N_CH  per-channel clear of pending flag and counter.
REQ-009 tick  output  N_CH  one-cycle registered edge pulse per channel.
REQ-010 pending  output  N_CH  sticky event flag per channel.
REQ-011 evt_cnt  output  N_CH*CNT_W  saturating event count; channel i at bits [CNT_W*i+CNT_W-1 : CNT_W*i].
REQ-012 any_tick  output  1  registered OR of all tick bits, same cycle as tick.

Function
REQ-013 Each channel SHALL run an independent Moore FSM with states ZERO, RISE, ONE, FALL; tick is decoded from state only.
REQ-014 Filter: a per-channel counter SHALL count consecutive samples differing from the accepted level and reset to 0 on any matching sample.
REQ-015 When the counter reaches FILT_LEN, ZERO/FALL SHALL go to RISE, or ONE/RISE SHALL go to FALL, on that edge.
REQ-016 RISE SHALL go to ONE and FALL to ZERO after one cycle unless REQ-015 fires again.
REQ-017 With FILT_LEN=1, a level change sampled at edge k SHALL give tick high during cycle k+1 (one-cycle latency).
REQ-018 With FILT_LEN=N, latency SHALL be N cycles from the first differing sample.
REQ-019 Pulses shorter than FILT_LEN samples SHALL produce no tick and no state change.
REQ-020 With FILT_LEN=1, reversal during RISE/FALL SHALL move directly to FALL/RISE, giving back-to-back ticks.
REQ-021 tick[i] = state in RISE with mode bit0 set, or state in FALL with mode bit1 set; mode 00 forces tick low while the FSM keeps tracking.
REQ-022 A mode change SHALL take effect on the next edge, produce no tick itself, and not disturb FSM or filter state.
REQ-023 pending[i] SHALL set on tick[i] and clear on clr[i]; if both occur in the same cycle, set wins.
REQ-024 evt_cnt[i] SHALL increment on tick[i] and saturate at 2^CNT_W-1; clr[i] zeroes it.
REQ-025 Simultaneous clr[i] and tick[i] SHALL load evt_cnt[i] with 1.
REQ-026 Channels SHALL not interact; simultaneous edges on all channels SHALL give simultaneous ticks.

Reset
REQ-027 Reset SHALL put every FSM in ZERO, zero every filter counter, and zero tick, any_tick, pending and evt_cnt.
REQ-028 Reset mid-pulse SHALL abort any pending tick with no tick in the cycle after reset.
REQ-029 A level held high through reset release SHALL report one rising event after FILT_LEN samples.

Configuration
REQ-030 With macro MULTI_EDGE_DETECTOR_SYNC_EN defined, each level bit SHALL pass through a two-flop synchronizer reset to 0 before the filter, adding exactly 2 cycles of latency.
REQ-031 Without the macro, level SHALL feed the filter directly; all other behaviour is identical.

Structure
REQ-032 Package edge_det_pkg SHALL hold the state encoding (ZERO=2'b00, RISE=2'b01, ONE=2'b11, FALL=2'b10) and the mode constants.
REQ-033 Sub-module edge_det_channel SHALL implement the filter, FSM, pending flag and counter for one channel, instantiated N_CH times by generate.

Verification
REQ-034 N_CH=4, FILT_LEN=1, mode=all 11; ch0 0->1 at edge 5 -> tick[0] high in cycle 6 only, evt_cnt[0]=1, pending[0]=1.
REQ-035 FILT_LEN=3, ch1 mode 01; 2-cycle high pulse -> no tick; then a 4-cycle high -> one tick[1] 3 cycles after the rise, none on the fall.
REQ-036 FILT_LEN=1, ch2 mode 11, level toggling every cycle for 6 cycles -> tick[2] high for 6 consecutive cycles, evt_cnt[2]=6.
REQ-037 CNT_W=2, 5 rising edges on ch3 -> evt_cnt[3]=3; clr[3] with a coincident tick -> evt_cnt[3]=1, pending[3]=1.
REQ-038 Reset asserted in the RISE cycle -> tick low in the following cycle, all outputs 0; level held 1 -> one tick FILT_LEN cycles after release.
REQ-039 With MULTI_EDGE_DETECTOR_SYNC_EN defined, repeat REQ-034 -> tick[0] in cycle 8.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared types for the multi-channel edge detector: FSM state encoding,
// per-channel mode constants and the state/mode -> tick decode.
package edge_det_pkg;

  // Width of the per-channel glitch filter counter (FILT_LEN up to 255)
  localparam int unsigned FILT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_ZERO = 2'b00,
    ST_RISE = 2'b01,
    ST_ONE  = 2'b11,
    ST_FALL = 2'b10
  } state_e;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Edge pulse is a pure decode of FSM state qualified by the channel mode
  function automatic logic tick_decode(input state_e st, input logic [1:0] md);
    logic t;
    t = 1'b0;
    case (md)
      MODE_OFF:  t = 1'b0;
      MODE_RISE: t = (st == ST_RISE);
      MODE_FALL: t = (st == ST_FALL);
      MODE_BOTH: t = (st == ST_RISE) || (st == ST_FALL);
    endcase
    return t;
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One detector channel: consecutive-sample glitch filter, ZERO/RISE/ONE/FALL
// Moore FSM, registered tick, sticky pending flag and saturating event counter.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int unsigned FILT_LEN = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             level_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  output logic             tick_o,
  output logic             tick_nxt_c,
  output logic             pending_o,
  output logic [CNT_W-1:0] evt_cnt_o
);

  localparam logic [FILT_CNT_W-1:0] FILT_MAX = FILT_CNT_W'(FILT_LEN);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_SAT  = {CNT_W{1'b1}};

  state_e                state_q, state_d;
  logic [FILT_CNT_W-1:0] filt_q, filt_d, filt_inc;
  logic                  accepted, differ;
  logic                  tick_q, tick_d;
  logic                  pending_q, pending_d;
  logic [CNT_W-1:0]      evt_q, evt_d;

  // FSM state and filter counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ZERO;
      filt_q  <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
    end
  end

  // Next state: settle RISE/FALL, flip accepted level once the filter fills
  always_comb begin
    state_d  = state_q;
    filt_d   = '0;
    accepted = (state_q == ST_ONE) || (state_q == ST_RISE);
    differ   = (level_i != accepted);
    filt_inc = filt_q + FILT_CNT_W'(1);
    case (state_q)
      ST_RISE: state_d = ST_ONE;
      ST_FALL: state_d = ST_ZERO;
      default: state_d = state_q;
    endcase
    if (differ) begin
      if (filt_inc == FILT_MAX) begin
        filt_d  = '0;
        state_d = accepted ? ST_FALL : ST_RISE;
      end else begin
        filt_d = filt_inc;
      end
    end
  end

  // Output next values: tick from next state, pending/counter from current tick
  always_comb begin
    tick_d    = tick_decode(state_d, mode_i);
    pending_d = tick_q | (pending_q & ~clr_i);
    evt_d     = evt_q;
    if (clr_i) begin
      evt_d = tick_q ? CNT_ONE : '0;
    end else if (tick_q && (evt_q != CNT_SAT)) begin
      evt_d = evt_q + CNT_ONE;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      evt_q     <= '0;
    end else begin
      tick_q    <= tick_d;
      pending_q <= pending_d;
      evt_q     <= evt_d;
    end
  end

  assign tick_o     = tick_q;
  assign tick_nxt_c = tick_d;
  assign pending_o  = pending_q;
  assign evt_cnt_o  = evt_q;

endmodule

// File: rtl/multi_edge_detector.sv
// N_CH independent filtered edge detectors with a shared any_tick summary.
// Define MULTI_EDGE_DETECTOR_SYNC_EN to insert a two-flop synchronizer on
// every level bit (adds two cycles of latency).
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned FILT_LEN = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       level,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       pending,
  output logic [N_CH*CNT_W-1:0] evt_cnt,
  output logic                  any_tick
);

  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] tick_nxt;
  logic            any_tick_q;

`ifdef MULTI_EDGE_DETECTOR_SYNC_EN
  logic [N_CH-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer ahead of the filters
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= level;
      sync2_q <= sync1_q;
    end
  end

  assign level_s = sync2_q;
`else
  assign level_s = level;
`endif

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    edge_det_channel #(
      .FILT_LEN (FILT_LEN),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .level_i    (level_s[i]),
      .mode_i     (mode[2*i +: 2]),
      .clr_i      (clr[i]),
      .tick_o     (tick[i]),
      .tick_nxt_c (tick_nxt[i]),
      .pending_o  (pending[i]),
      .evt_cnt_o  (evt_cnt[CNT_W*i +: CNT_W])
    );
  end

  // Summary pulse registered alongside the per-channel ticks
  always_ff @(posedge clk) begin
    if (reset) any_tick_q <= 1'b0;
    else       any_tick_q <= |tick_nxt;
  end

  assign any_tick = any_tick_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: dut_a uses FILT_LEN=1/CNT_W=8,
// dut_b uses FILT_LEN=3/CNT_W=2. Extra synchronizer latency is folded in
// when MULTI_EDGE_DETECTOR_SYNC_EN is defined.
module tb_multi_edge_detector;

`ifdef MULTI_EDGE_DETECTOR_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk;
  logic        ra, rb;
  logic [3:0]  lv_a, lv_b, clr_a, clr_b;
  logic [7:0]  md_a, md_b;
  logic [3:0]  tk_a, tk_b, pd_a, pd_b;
  logic [31:0] ec_a;
  logic [7:0]  ec_b;
  logic        at_a, at_b;

  int n_cmp;
  int n_bad;

  multi_edge_detector #(.N_CH(4), .FILT_LEN(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(ra), .level(lv_a), .mode(md_a), .clr(clr_a),
    .tick(tk_a), .pending(pd_a), .evt_cnt(ec_a), .any_tick(at_a)
  );

  multi_edge_detector #(.N_CH(4), .FILT_LEN(3), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rb), .level(lv_b), .mode(md_b), .clr(clr_b),
    .tick(tk_b), .pending(pd_b), .evt_cnt(ec_b), .any_tick(at_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Cycles until tick[ch] of dut_a rises, -1 if budget expires
  task automatic wait_tick_a(input int ch, input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget && lat < 0; c++) begin
      tick_clk();
      if (tk_a[ch]) lat = c;
    end
  endtask

  task automatic wait_tick_b(input int ch, input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget && lat < 0; c++) begin
      tick_clk();
      if (tk_b[ch]) lat = c;
    end
  endtask

  task automatic test_reset();
    ra = 1'b1; rb = 1'b1;
    lv_a = '0; lv_b = '0; clr_a = '0; clr_b = '0;
    md_a = 8'hFF;
    md_b = 8'b01_11_01_11;
    repeat (3) tick_clk();
    ra = 1'b0; rb = 1'b0;
    n_cmp++; if (tk_a !== 4'h0) begin n_bad++; $display("FAIL reset_tick_a: got %h want 0", tk_a); end
    n_cmp++; if (pd_a !== 4'h0) begin n_bad++; $display("FAIL reset_pend_a: got %h want 0", pd_a); end
    n_cmp++; if (ec_a !== 32'h0) begin n_bad++; $display("FAIL reset_cnt_a: got %h want 0", ec_a); end
    n_cmp++; if (at_a !== 1'b0) begin n_bad++; $display("FAIL reset_any_a: got %b want 0", at_a); end
    n_cmp++; if (tk_b !== 4'h0) begin n_bad++; $display("FAIL reset_tick_b: got %h want 0", tk_b); end
    n_cmp++; if (pd_b !== 4'h0) begin n_bad++; $display("FAIL reset_pend_b: got %h want 0", pd_b); end
    n_cmp++; if (ec_b !== 8'h0) begin n_bad++; $display("FAIL reset_cnt_b: got %h want 0", ec_b); end
    n_cmp++; if (at_b !== 1'b0) begin n_bad++; $display("FAIL reset_any_b: got %b want 0", at_b); end
  endtask

  task automatic test_single_edge();
    int lat;
    lv_a[0] = 1'b1;
    wait_tick_a(0, 8, lat);
    n_cmp++; if (lat != 1 + SYNC_LAT) begin n_bad++; $display("FAIL edge_latency: got %0d want %0d", lat, 1 + SYNC_LAT); end
    n_cmp++; if (tk_a !== 4'b0001) begin n_bad++; $display("FAIL edge_tick: got %b want 0001", tk_a); end
    n_cmp++; if (at_a !== 1'b1) begin n_bad++; $display("FAIL edge_any: got %b want 1", at_a); end
    tick_clk();
    n_cmp++; if (tk_a !== 4'b0000) begin n_bad++; $display("FAIL edge_one_cycle: got %b want 0000", tk_a); end
    n_cmp++; if (ec_a[7:0] !== 8'd1) begin n_bad++; $display("FAIL edge_cnt: got %0d want 1", ec_a[7:0]); end
    n_cmp++; if (pd_a[0] !== 1'b1) begin n_bad++; $display("FAIL edge_pend: got %b want 1", pd_a[0]); end
  endtask

  task automatic test_mode();
    int seen;
    int lat;
    seen = 0;
    md_a[3:2] = 2'b00;
    lv_a[1] = 1'b1;
    repeat (4 + SYNC_LAT) begin tick_clk(); seen += int'(tk_a[1]); end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL mode_off: got %0d ticks want 0", seen); end
    md_a[3:2] = 2'b11;
    tick_clk();
    n_cmp++; if (tk_a[1] !== 1'b0) begin n_bad++; $display("FAIL mode_change: got %b want 0", tk_a[1]); end
    lv_a[1] = 1'b0;
    wait_tick_a(1, 8, lat);
    n_cmp++; if (lat != 1 + SYNC_LAT) begin n_bad++; $display("FAIL mode_tracked_fall: got %0d want %0d", lat, 1 + SYNC_LAT); end
    tick_clk();
    n_cmp++; if (ec_a[15:8] !== 8'd1) begin n_bad++; $display("FAIL mode_cnt: got %0d want 1", ec_a[15:8]); end
  endtask

  task automatic test_clr();
    clr_a[0] = 1'b1;
    tick_clk();
    clr_a = '0;
    n_cmp++; if (pd_a[0] !== 1'b0) begin n_bad++; $display("FAIL clr_pend: got %b want 0", pd_a[0]); end
    n_cmp++; if (ec_a[7:0] !== 8'd0) begin n_bad++; $display("FAIL clr_cnt: got %0d want 0", ec_a[7:0]); end
  endtask

  task automatic test_toggle();
    int total;
    int run;
    int best;
    total = 0; run = 0; best = 0;
    for (int i = 0; i < 10 + SYNC_LAT; i++) begin
      if (i < 6) lv_a[2] = ~lv_a[2];
      tick_clk();
      if (tk_a[2]) begin
        total++; run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    n_cmp++; if (total != 6) begin n_bad++; $display("FAIL toggle_total: got %0d want 6", total); end
    n_cmp++; if (best != 6) begin n_bad++; $display("FAIL toggle_run: got %0d want 6", best); end
    tick_clk();
    n_cmp++; if (ec_a[23:16] !== 8'd6) begin n_bad++; $display("FAIL toggle_cnt: got %0d want 6", ec_a[23:16]); end
  endtask

  task automatic test_back_to_back();
    int lat;
    lv_a = 4'h0;
    repeat (4 + SYNC_LAT) tick_clk();
    lv_a = 4'hF;
    wait_tick_a(3, 8, lat);
    n_cmp++; if (tk_a !== 4'hF) begin n_bad++; $display("FAIL simul_tick: got %b want 1111", tk_a); end
    n_cmp++; if (at_a !== 1'b1) begin n_bad++; $display("FAIL simul_any: got %b want 1", at_a); end
  endtask

  task automatic test_filter();
    int seen;
    int lat;
    seen = 0;
    lv_b[1] = 1'b1;
    repeat (2) begin tick_clk(); seen += int'(tk_b[1]); end
    lv_b[1] = 1'b0;
    repeat (6 + SYNC_LAT) begin tick_clk(); seen += int'(tk_b[1]); end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL filt_glitch: got %0d ticks want 0", seen); end
    n_cmp++; if (ec_b[3:2] !== 2'd0) begin n_bad++; $display("FAIL filt_glitch_cnt: got %0d want 0", ec_b[3:2]); end
    lv_b[1] = 1'b1;
    wait_tick_b(1, 10, lat);
    n_cmp++; if (lat != 3 + SYNC_LAT) begin n_bad++; $display("FAIL filt_latency: got %0d want %0d", lat, 3 + SYNC_LAT); end
    tick_clk();
    lv_b[1] = 1'b0;
    seen = 0;
    repeat (8 + SYNC_LAT) begin tick_clk(); seen += int'(tk_b[1]); end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL filt_no_fall: got %0d ticks want 0", seen); end
    n_cmp++; if (ec_b[3:2] !== 2'd1) begin n_bad++; $display("FAIL filt_cnt: got %0d want 1", ec_b[3:2]); end
  endtask

  task automatic test_saturate();
    int lat;
    for (int k = 0; k < 5; k++) begin
      lv_b[3] = 1'b1;
      repeat (5 + SYNC_LAT) tick_clk();
      lv_b[3] = 1'b0;
      repeat (5 + SYNC_LAT) tick_clk();
    end
    n_cmp++; if (ec_b[7:6] !== 2'd3) begin n_bad++; $display("FAIL sat_cnt: got %0d want 3", ec_b[7:6]); end
    n_cmp++; if (pd_b[3] !== 1'b1) begin n_bad++; $display("FAIL sat_pend: got %b want 1", pd_b[3]); end
    lv_b[3] = 1'b1;
    wait_tick_b(3, 10, lat);
    n_cmp++; if (lat != 3 + SYNC_LAT) begin n_bad++; $display("FAIL sat_tick_latency: got %0d want %0d", lat, 3 + SYNC_LAT); end
    clr_b[3] = 1'b1;
    tick_clk();
    clr_b = '0;
    n_cmp++; if (ec_b[7:6] !== 2'd1) begin n_bad++; $display("FAIL clr_tick_cnt: got %0d want 1", ec_b[7:6]); end
    n_cmp++; if (pd_b[3] !== 1'b1) begin n_bad++; $display("FAIL clr_tick_pend: got %b want 1", pd_b[3]); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    lv_b = 4'h0;
    repeat (6 + SYNC_LAT) tick_clk();
    lv_b[0] = 1'b1;
    wait_tick_b(0, 10, lat);
    n_cmp++; if (lat != 3 + SYNC_LAT) begin n_bad++; $display("FAIL rmid_rise: got %0d want %0d", lat, 3 + SYNC_LAT); end
    rb = 1'b1;
    tick_clk();
    rb = 1'b0;
    n_cmp++; if (tk_b !== 4'h0) begin n_bad++; $display("FAIL rmid_tick: got %b want 0000", tk_b); end
    n_cmp++; if (at_b !== 1'b0) begin n_bad++; $display("FAIL rmid_any: got %b want 0", at_b); end
    n_cmp++; if (pd_b !== 4'h0) begin n_bad++; $display("FAIL rmid_pend: got %b want 0000", pd_b); end
    n_cmp++; if (ec_b !== 8'h0) begin n_bad++; $display("FAIL rmid_cnt: got %h want 00", ec_b); end
    wait_tick_b(0, 10, lat);
    n_cmp++; if (lat != 3 + SYNC_LAT) begin n_bad++; $display("FAIL rmid_release: got %0d want %0d", lat, 3 + SYNC_LAT); end
    n_cmp++; if (tk_b !== 4'b0001) begin n_bad++; $display("FAIL rmid_release_vec: got %b want 0001", tk_b); end
    seen = 0;
    repeat (6) begin tick_clk(); seen += int'(tk_b[0]); end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rmid_single: got %0d extra ticks want 0", seen); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_edge();
    test_mode();
    test_clr();
    test_toggle();
    test_back_to_back();
    test_filter();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
